// File: rtl/enet_mdio_pkg.sv
// rtl/enet_mdio_pkg.sv - Clause-22 MDIO frame constants, state enum and frame builder
package enet_mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int MDIO_PRE_BITS   = 32;
  localparam int MDIO_FRAME_BITS = 64;
  localparam int MDIO_TA_BIT     = 46;
  localparam int MDIO_DATA_BIT   = 48;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } mdio_state_e;

  // Read frames carry all 1s in TA/DATA so the released line idles high.
  function automatic logic [63:0] mdio_build_frame(input logic wr, input logic [4:0] phyad,
                                                   input logic [4:0] regad, input logic [15:0] wdata);
    return {{MDIO_PRE_BITS{1'b1}}, MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad,
            (wr ? MDIO_TA_WR : 2'b11), (wr ? wdata : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/enet_mdc_tick.sv
// rtl/enet_mdc_tick.sv - MDC half-period counter marking the first, mid and last cycle of a bit
module enet_mdc_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic fall_stb,
  output logic half_last,
  output logic rise_last
);

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);

  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (cnt_q == BIT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  assign fall_stb  = run && (cnt_q == 9'd0);
  assign half_last = run && (cnt_q == HALF_LAST);
  assign rise_last = run && (cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enet_mdio_master.sv
// rtl/enet_mdio_master.sv - Clause-22 MDIO master: one register read/write per command
module enet_mdio_master
  import enet_mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  mdio_state_e state_q, state_d;
  logic        wr_q, wr_d;
  logic [63:0] frame_q, frame_d;
  logic [5:0]  bit_q, bit_d;
  logic [15:0] rd_q, rd_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        mdc_q, mdc_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;

  logic        accept;
  logic        oe_next;
  logic [63:0] new_frame;
  logic        fall_stb, half_last, rise_last;

  assign accept    = cmd_valid && cmd_ready_q;
  assign new_frame = mdio_build_frame(cmd_write, cmd_phy, cmd_reg, cmd_wdata);

  enet_mdc_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .run       (state_q == ST_SHIFT),
    .fall_stb  (fall_stb),
    .half_last (half_last),
    .rise_last (rise_last)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    rd_d        = rd_q;
    sync1_d     = mdio_i;
    sync2_d     = sync1_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mdc_d       = mdc_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    oe_next     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        mdc_d       = 1'b0;
        mdio_o_d    = 1'b1;
        mdio_oe_d   = 1'b0;
        if (accept) begin
          state_d     = ST_SHIFT;
          wr_d        = cmd_write;
          frame_d     = new_frame;
          bit_d       = '0;
          cmd_ready_d = 1'b0;
          mdio_o_d    = new_frame[63];
          mdio_oe_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // frame_q[63] is pre-advanced to the next bit so rise_last can load it.
        if (fall_stb) begin
          frame_d = {frame_q[62:0], 1'b1};
        end
        if (half_last) begin
          mdc_d = 1'b1;
        end
        if (rise_last) begin
          mdc_d = 1'b0;
          if (bit_q >= 6'(MDIO_DATA_BIT)) begin
            rd_d = {rd_q[14:0], sync2_q};
          end
          if (bit_q == 6'(MDIO_FRAME_BITS - 1)) begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b1;
            mdio_o_d    = 1'b1;
            mdio_oe_d   = 1'b0;
            if (!wr_q) begin
              rsp_rdata_d = {rd_q[14:0], sync2_q};
            end
          end else begin
            bit_d     = bit_q + 6'd1;
            oe_next   = wr_q || (bit_q < 6'(MDIO_TA_BIT - 1));
            mdio_oe_d = oe_next;
            mdio_o_d  = oe_next ? frame_q[63] : 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      frame_q     <= '1;
      bit_q       <= '0;
      rd_q        <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      rd_q        <= rd_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mdc_q       <= mdc_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_enet_mdio_master.sv
// tb/tb_enet_mdio_master.sv - scoreboard bench for enet_mdio_master at CLK_DIV 4 and 3
module tb_enet_mdio_master;

  localparam int D = 4;
  localparam int LAT4 = 128 * D + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rsp_rdata;
  logic        phy_drv = 1'b1;
  assign mdio_i = mdio_oe ? mdio_o : phy_drv;

  logic        c3_valid = 1'b0, c3_write = 1'b1;
  logic [4:0]  c3_phy = 5'h05, c3_reg = 5'h11;
  logic [15:0] c3_wdata = 16'h1234;
  logic        c3_ready, c3_rsp_valid, c3_mdc, c3_o, c3_oe, c3_i;
  logic [15:0] c3_rdata;
  assign c3_i = c3_oe ? c3_o : 1'b1;

  enet_mdio_master #(.CLK_DIV(D)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  enet_mdio_master #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_write(c3_write), .cmd_phy(c3_phy), .cmd_reg(c3_reg), .cmd_wdata(c3_wdata),
    .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rdata), .mdc(c3_mdc), .mdio_o(c3_o),
    .mdio_oe(c3_oe), .mdio_i(c3_i)
  );

  typedef struct {
    logic [15:0] rdata;
    int          cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, tcyc = 0, bit_idx = 0, oe_fall_cyc = -1, acc_gap = -1, acc_cnt = 0;
  int last_rise = -1, max_gap = 0, rise_cnt = 0;
  logic [63:0] rx_vec = '0, rx_oe = '0;
  logic [15:0] phy_data = '0, last_rd = '0;
  logic        mdc_prev = 1'b0, oe_prev = 1'b0;

  // One cycle of the DUT4 environment: PHY model, bit monitor, response capture.
  task automatic step();
    logic acc;
    acc = cmd_valid && cmd_ready;
    @(negedge clk);
    tcyc++;
    if (acc) begin
      acc_gap = cyc;
      acc_cnt++;
      cyc = 1;
      bit_idx = 0;
    end else begin
      cyc++;
    end
    if (mdc && !mdc_prev) begin
      if (bit_idx < 64) begin
        rx_vec[6'(63 - bit_idx)] = mdio_o;
        rx_oe[6'(63 - bit_idx)]  = mdio_oe;
      end
      bit_idx++;
      rise_cnt++;
      if (last_rise >= 0 && (tcyc - last_rise) > max_gap) max_gap = tcyc - last_rise;
      last_rise = tcyc;
    end
    if (!mdc && mdc_prev) begin
      phy_drv = (bit_idx >= 48 && bit_idx < 64) ? phy_data[4'(63 - bit_idx)] : 1'b1;
    end
    if (oe_prev && !mdio_oe) oe_fall_cyc = cyc;
    if (rsp_valid) obs_q.push_back('{rsp_rdata, cyc});
    mdc_prev = mdc;
    oe_prev  = mdio_oe;
  endtask

  task automatic send(input logic wr, input logic [4:0] phy, input logic [4:0] regad,
                      input logic [15:0] wdata, input logic hold);
    int a0, n;
    if (!wr) last_rd = phy_data;
    exp_q.push_back('{last_rd, LAT4});
    cmd_write = wr;
    cmd_phy   = phy;
    cmd_reg   = regad;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt == a0 && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (acc_cnt == a0) begin
      failures++;
      $display("FAIL accept_timeout: no accept after %0d cycles, required accept", n);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n_obs);
    int n;
    n = 0;
    while (obs_q.size() < n_obs && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (obs_q.size() < n_obs) begin
      failures++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", obs_q.size(), n_obs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({cmd_ready, rsp_valid, mdc, mdio_o, mdio_oe} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_outputs: ready,rsp,mdc,o,oe=%b required 00010",
               {cmd_ready, rsp_valid, mdc, mdio_o, mdio_oe});
    end
    checks++;
    if (rsp_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata: got %h required 0000", rsp_rdata);
    end
    reset = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_t e, o;
    logic [63:0] want;
    want = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h8140};
    send(1'b1, 5'h01, 5'h00, 16'h8140, 1'b0);
    wait_rsp(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL write_latency: rsp at cycle %0d required %0d", o.cyc, e.cyc);
      end
      checks++;
      if (o.rdata !== e.rdata) begin
        failures++;
        $display("FAIL write_rdata: got %h required %h", o.rdata, e.rdata);
      end
    end
    checks++;
    if (rx_vec !== want) begin
      failures++;
      $display("FAIL write_stream: got %h required %h", rx_vec, want);
    end
    checks++;
    if (rx_oe !== 64'hFFFF_FFFF_FFFF_FFFF || bit_idx != 64) begin
      failures++;
      $display("FAIL write_oe: oe %h bits %0d required all ones and 64", rx_oe, bit_idx);
    end
  endtask

  task automatic test_read();
    rsp_t e, o;
    logic [63:0] want;
    want = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02, 18'h3FFFF};
    phy_data = 16'h0141;
    oe_fall_cyc = -1;
    send(1'b0, 5'h03, 5'h02, 16'hDEAD, 1'b0);
    wait_rsp(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL read_rsp: rdata %h cycle %0d required %h cycle %0d",
                 o.rdata, o.cyc, e.rdata, e.cyc);
      end
    end
    checks++;
    if (oe_fall_cyc != 1 + 2 * 46 * D) begin
      failures++;
      $display("FAIL read_oe_fall: cycle %0d required %0d", oe_fall_cyc, 1 + 2 * 46 * D);
    end
    checks++;
    if (rx_oe !== {{46{1'b1}}, 18'h0}) begin
      failures++;
      $display("FAIL read_oe_bits: got %h required %h", rx_oe, {{46{1'b1}}, 18'h0});
    end
    checks++;
    if (rx_vec !== want) begin
      failures++;
      $display("FAIL read_stream: got %h required %h", rx_vec, want);
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e, o;
    phy_data  = 16'h5A3C;
    last_rise = -1;
    max_gap   = 0;
    rise_cnt  = 0;
    send(1'b0, 5'h07, 5'h1F, 16'h0000, 1'b1);
    send(1'b1, 5'h07, 5'h04, 16'hC3A5, 1'b0);
    wait_rsp(2);
    checks++;
    if (acc_gap != LAT4) begin
      failures++;
      $display("FAIL b2b_accept: second accept at cycle %0d required %0d", acc_gap, LAT4);
    end
    checks++;
    if (rise_cnt != 128 || max_gap != 2 * D + 1) begin
      failures++;
      $display("FAIL b2b_mdc: rises %0d max gap %0d required 128 and %0d",
               rise_cnt, max_gap, 2 * D + 1);
    end
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o.rdata !== e.rdata || o.cyc !== e.cyc) begin
          failures++;
          $display("FAIL b2b_rsp%0d: rdata %h cycle %0d required %h cycle %0d",
                   i, o.rdata, o.cyc, e.rdata, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    int n;
    phy_data = 16'hA5A5;
    send(1'b0, 5'h02, 5'h09, 16'h0000, 1'b0);
    n = 0;
    while (!(bit_idx == 41 && mdc) && n < 2000) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    checks++;
    if ({mdc, mdio_oe, cmd_ready} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_outputs: mdc,oe,ready=%b required 000", {mdc, mdio_oe, cmd_ready});
    end
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    last_rd = 16'h0000;
    repeat (600) step();
    checks++;
    if (obs_q.size() != 0 || rsp_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_no_rsp: responses %0d rdata %h required 0 and 0000",
               obs_q.size(), rsp_rdata);
    end
    obs_q.delete();
    phy_data = 16'hBEEF;
    send(1'b0, 5'h02, 5'h09, 16'h0000, 1'b0);
    wait_rsp(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL midreset_recover: rdata %h cycle %0d required %h cycle %0d",
                 o.rdata, o.cyc, e.rdata, e.cyc);
      end
    end
  endtask

  task automatic test_div3();
    int bad_idle, bad_mdc, bad_rsp;
    logic want_mdc;
    bad_idle = 0;
    bad_mdc  = 0;
    bad_rsp  = 0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if ({c3_ready, c3_rsp_valid, c3_mdc, c3_o, c3_oe} !== 5'b10010) bad_idle++;
      @(negedge clk);
    end
    checks++;
    if (bad_idle != 0) begin
      failures++;
      $display("FAIL div3_idle: %0d non-idle cycles required 0", bad_idle);
    end
    c3_valid = 1'b1;
    @(negedge clk);
    c3_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      want_mdc = (k <= 384) && (((k - 1) % 6) >= 3);
      if (c3_mdc !== want_mdc) bad_mdc++;
      if (c3_rsp_valid !== (k == 385)) bad_rsp++;
      @(negedge clk);
    end
    checks++;
    if (bad_mdc != 0) begin
      failures++;
      $display("FAIL div3_mdc: %0d wrong mdc cycles required 0", bad_mdc);
    end
    checks++;
    if (bad_rsp != 0 || c3_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL div3_rsp: %0d wrong rsp cycles rdata %h required 0 and 0000",
               bad_rsp, c3_rdata);
    end
  endtask

  task automatic test_hold();
    rsp_t e, o;
    phy_data = 16'hFFFF;
    send(1'b0, 5'h01, 5'h01, 16'h0000, 1'b0);
    wait_rsp(1);
    send(1'b1, 5'h01, 5'h00, 16'h1200, 1'b0);
    wait_rsp(2);
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o.rdata !== e.rdata || o.cyc !== e.cyc) begin
          failures++;
          $display("FAIL hold_rsp%0d: rdata %h cycle %0d required %h cycle %0d",
                   i, o.rdata, o.cyc, e.rdata, e.cyc);
        end
      end
    end
    repeat (5) step();
    checks++;
    if (rsp_rdata !== 16'hFFFF) begin
      failures++;
      $display("FAIL hold_after_write: got %h required FFFF", rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_div3();
    test_hold();
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: expected left %0d observed left %0d required 0 and 0",
               exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
